sram_rr_arb: RTL and testbench
==============================

SRAM_RR_ARB -- requirements
Module: sram_rr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width (multiple of 8).
REQ-004 SHALL have port clk_i  input  1  sole clock; one clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_i  input  NUM_REQ  per-requester access request.
REQ-007 SHALL have port lock_i  input  NUM_REQ  per-requester hold-grant request.
REQ-008 SHALL have port wen_i  input  NUM_REQ  per-requester write (1) / read (0).
REQ-009 SHALL have port bm_i  input  NUM_REQ x DATA_WIDTH/8  per-requester byte mask, 1 = byte written.
REQ-010 SHALL have port addr_i  input  NUM_REQ x ADDR_WIDTH  per-requester address.
REQ-011 SHALL have port dat_i  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-012 SHALL have port gnt_o  output  NUM_REQ  one-hot grant, combinational.
REQ-013 SHALL have port rvalid_o  output  NUM_REQ  read data valid for that requester.
REQ-014 SHALL have port rdata_o  output  DATA_WIDTH  read data, broadcast to all requesters.
REQ-015 SHALL have ports sram_en_o, sram_wen_o (output 1), sram_bm_o (output DATA_WIDTH/8), sram_addr_o (output ADDR_WIDTH), sram_dat_o (output DATA_WIDTH): active-high single SRAM port.
REQ-016 SHALL have port sram_dat_i  input  DATA_WIDTH  SRAM read data, valid one cycle after read enable.

Function
REQ-017 SHALL grant at most one requester per cycle; gnt_o is zero when req_i is zero.
REQ-018 SHALL grant combinationally in the cycle req_i is seen; the transfer completes in the cycle gnt_o[k]=1.
REQ-019 Requester SHALL hold req/wen/bm/addr/dat stable until it sees gnt; arbiter SHALL NOT depend on this.
REQ-020 SHALL use round-robin: search order starts at register ptr_q, ascending, wrapping at NUM_REQ-1 to 0.
REQ-021 SHALL update ptr_q to (k+1) mod NUM_REQ on each grant to k; ptr_q unchanged when no grant.
REQ-022 Lock: if grant to k had lock_i[k]=1, SHALL set owner_valid_q=1, owner_q=k.
REQ-023 While owner_valid_q=1 and req_i[owner_q]=1, SHALL grant owner_q regardless of ptr_q.
REQ-024 SHALL clear owner_valid_q at the first cycle req_i[owner_q]=0, or on a grant with lock_i[owner_q]=0; round-robin arbitration applies that same cycle.
REQ-025 SHALL drive sram_en_o=|gnt_o; sram_wen_o/bm/addr/dat from granted requester; all zero when no grant.
REQ-026 On read grant to k, SHALL assert rvalid_o[k] exactly one cycle later, rdata_o=sram_dat_i in that cycle.
REQ-027 SHALL assert rvalid_o for no requester after a write grant; rvalid_o is one-hot or zero.
REQ-028 Back-to-back reads (same or different requesters) SHALL be supported every cycle, full throughput, no bubbles.
REQ-029 rdata_o SHALL pass sram_dat_i through combinationally; no data register.
REQ-030 Write then read of the same address on consecutive grants SHALL return the written data (SRAM write-first ordering relied upon, no bypass in arbiter).

Reset
REQ-031 On rst_i=1, SHALL asynchronously set ptr_q=0, owner_valid_q=0, owner_q=0, pending-read register=0.
REQ-032 During reset, rvalid_o SHALL be 0; gnt_o and sram_* follow REQ-025 from reset state.
REQ-033 Reset asserted the cycle after a read grant SHALL suppress that rvalid_o.
REQ-034 First grant after reset SHALL follow ptr_q=0 (requester 0 highest priority).

Verification
REQ-035 Reset, req_i=4'b1111 held 5 cycles, no lock -> gnt_o sequence 0001,0010,0100,1000,0001.
REQ-036 req_i[2] read addr 0x40, with 0x40 preloaded 0xDEADBEEF -> sram_en_o=1, sram_wen_o=0 same cycle; next cycle rvalid_o=4'b0100, rdata_o=0xDEADBEEF.
REQ-037 req_i=4'b0011, lock_i[1]=1 from first grant of 1 for 3 cycles -> after 0001, gnt_o=0010 x3 then 0001 when lock drops.
REQ-038 Requester 0 writes 0x12345678 bm=4'b0011 to 0x10 (old 0xAAAAAAAA), requester 1 reads 0x10 next cycle -> rvalid_o=4'b0010, rdata_o=0xAAAA5678.
REQ-039 Read grant to requester 3, rst_i pulsed next cycle -> rvalid_o stays 0; next grant with req_i=4'b1000|4'b0001 goes to requester 0.
REQ-040 Random req/lock/wen 10k cycles vs reference model -> gnt one-hot, no requester waits more than NUM_REQ-1 grants while no lock held, all read data match.

Source files
------------

// File: rtl/sram_rr_arb.sv
// sram_rr_arb: round-robin arbiter in front of a single-port SRAM.
// Up to NUM_REQ requesters share one SRAM port. A request is granted
// combinationally and the SRAM access happens in that same cycle. Read data
// comes back one cycle later and is broadcast, qualified by a one-hot
// rvalid_o. A granted requester can raise lock_i to keep the port for
// back-to-back transfers for as long as it keeps requesting.
module sram_rr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ-1:0]                 lock_i,
  input  logic [NUM_REQ-1:0]                 wen_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  bm_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      dat_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  output logic [NUM_REQ-1:0]                 rvalid_o,
  output logic [DATA_WIDTH-1:0]              rdata_o,
  output logic                               sram_en_o,
  output logic                               sram_wen_o,
  output logic [DATA_WIDTH/8-1:0]            sram_bm_o,
  output logic [ADDR_WIDTH-1:0]              sram_addr_o,
  output logic [DATA_WIDTH-1:0]              sram_dat_o,
  input  logic [DATA_WIDTH-1:0]              sram_dat_i
);

  localparam int            BW   = DATA_WIDTH / 8;
  localparam int            IW   = $clog2(NUM_REQ);
  localparam logic [IW:0]   LP_N = (IW+1)'(NUM_REQ);

  // Round-robin pointer: the requester searched first this cycle.
  logic [IW-1:0]      r_ptr;
  // Lock owner: while valid and still requesting, it wins unconditionally.
  logic               r_owner_valid;
  logic [IW-1:0]      r_owner;
  // One-hot record of last cycle's read grant; drives rvalid_o directly.
  logic [NUM_REQ-1:0] r_rd_pend;

  logic               w_owner_hold;
  logic               w_rr_hit;
  logic [IW-1:0]      w_rr_idx;
  logic               w_gnt_hit;
  logic [IW-1:0]      w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_ptr_next;

  // Reduce a value in [0, 2*NUM_REQ) to a requester index (mod NUM_REQ).
  function automatic logic [IW-1:0] f_wrap(input logic [IW:0] v);
    logic [IW:0] t;
    t = (v >= LP_N) ? (v - LP_N) : v;
    return t[IW-1:0];
  endfunction

  // The owner keeps the port only while it is still requesting; once it
  // drops req the normal round-robin search takes over in the same cycle.
  assign w_owner_hold = r_owner_valid & req_i[r_owner];

  // Round-robin search: first requester at or after r_ptr, wrapping.
  always_comb begin
    logic [IW-1:0] v_cand;
    v_cand   = '0;
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_cand = f_wrap({1'b0, r_ptr} + (IW+1)'(i));
      if (!w_rr_hit && req_i[v_cand]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = v_cand;
      end
    end
  end

  // Final grant selection: lock owner first, otherwise round-robin winner.
  always_comb begin
    w_gnt_hit = w_owner_hold | w_rr_hit;
    w_gnt_idx = w_owner_hold ? r_owner : w_rr_idx;
    w_gnt     = '0;
    if (w_gnt_hit) begin
      w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  assign gnt_o      = w_gnt;
  assign w_ptr_next = f_wrap({1'b0, w_gnt_idx} + (IW+1)'(1));

  // SRAM port mux: the granted requester's fields, all zero when idle.
  always_comb begin
    sram_en_o   = 1'b0;
    sram_wen_o  = 1'b0;
    sram_bm_o   = '0;
    sram_addr_o = '0;
    sram_dat_o  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        sram_en_o   = 1'b1;
        sram_wen_o  = wen_i[k];
        sram_bm_o   = bm_i[k*BW +: BW];
        sram_addr_o = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sram_dat_o  = dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin pointer advances past each granted requester.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_gnt_hit) begin
      r_ptr <= w_ptr_next;
    end
  end

  // Lock ownership: taken by a grant with lock set, released by a grant
  // without lock or by any cycle in which nobody is granted (which implies
  // the owner has dropped its request).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner_valid <= 1'b0;
      r_owner       <= '0;
    end else if (w_gnt_hit) begin
      r_owner_valid <= lock_i[w_gnt_idx];
      if (lock_i[w_gnt_idx]) begin
        r_owner <= w_gnt_idx;
      end
    end else begin
      r_owner_valid <= 1'b0;
    end
  end

  // Read-return tracking: a read grant flags its requester for exactly one
  // cycle; an async reset in that cycle cancels the return.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_pend <= '0;
    end else begin
      r_rd_pend <= w_gnt & ~wen_i;
    end
  end

  assign rvalid_o = r_rd_pend;
  assign rdata_o  = sram_dat_i;

endmodule

// File: tb/tb_sram_rr_arb.sv
// Self-checking bench for sram_rr_arb: table of grant/rvalid vectors,
// hand-written data-path sequences, then randomized traffic compared
// against a behavioural reference model of the arbitration rules.
module tb_sram_rr_arb;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i, lock_i, wen_i;
  logic [N*BW-1:0] bm_i;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] dat_i;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            sram_en_o, sram_wen_o;
  logic [BW-1:0]   sram_bm_o;
  logic [AW-1:0]   sram_addr_o;
  logic [DW-1:0]   sram_dat_o;
  logic [DW-1:0]   sram_dat_i = '0;

  int errors = 0;
  int checks = 0;

  sram_rr_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .lock_i(lock_i),
    .wen_i(wen_i), .bm_i(bm_i), .addr_i(addr_i), .dat_i(dat_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .sram_en_o(sram_en_o), .sram_wen_o(sram_wen_o), .sram_bm_o(sram_bm_o),
    .sram_addr_o(sram_addr_o), .sram_dat_o(sram_dat_o), .sram_dat_i(sram_dat_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] bm);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (bm[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // SRAM model: byte-masked write, registered read, one-cycle latency.
  logic [31:0] sram_mem [0:255] = '{default: 32'h0};
  always @(posedge clk_i) begin
    if (sram_en_o) begin
      if (sram_wen_o)
        sram_mem[sram_addr_o[9:2]] <= merge(sram_mem[sram_addr_o[9:2]], sram_dat_o, sram_bm_o);
      else
        sram_dat_i <= sram_mem[sram_addr_o[9:2]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int k, input logic w, input logic [3:0] bm,
                         input logic [31:0] a, input logic [31:0] d);
    wen_i[k]          = w;
    bm_i[k*BW +: BW]  = bm;
    addr_i[k*AW +: AW] = a;
    dat_i[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_i = '0; lock_i = '0;
    next_cycle();
    rst_i = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int          m_ptr;
  int          m_owner;     // -1: no lock owner
  logic [31:0] ref_mem [0:255];
  logic [N-1:0] exp_rv;
  logic [31:0] exp_rdata;

  function automatic int model_pick();
    if (m_owner >= 0 && req_i[m_owner]) return m_owner;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req_i[k]) return k;
    end
    return -1;
  endfunction

  typedef struct {
    bit         rst;
    logic [3:0] req, lock, wen, gnt, rv;
  } vec_t;
  vec_t tbl [19];

  bit   pend [N];
  int   waitc [N];
  int   last_g, g, gd;
  logic [N-1:0] eg;
  logic [31:0]  ea;

  initial begin
    rst_i = 1'b1; req_i = '0; lock_i = '0; wen_i = '0;
    bm_i = '0; addr_i = '0; dat_i = '0;

    //            rst  req      lock     wen      gnt      rvalid
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0010};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0100};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b1000};
    tbl[6]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    tbl[7]  = '{1'b0, 4'b0011, 4'b0000, 4'b1111, 4'b0001, 4'b0000};
    tbl[8]  = '{1'b0, 4'b0011, 4'b0010, 4'b1111, 4'b0010, 4'b0000};
    tbl[9]  = '{1'b0, 4'b0011, 4'b0010, 4'b1111, 4'b0010, 4'b0000};
    tbl[10] = '{1'b0, 4'b0011, 4'b0000, 4'b1111, 4'b0010, 4'b0000};
    tbl[11] = '{1'b0, 4'b0011, 4'b0000, 4'b1111, 4'b0001, 4'b0000};
    tbl[12] = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
    tbl[13] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    tbl[15] = '{1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    tbl[16] = '{1'b0, 4'b1010, 4'b1000, 4'b0000, 4'b1000, 4'b0010};
    tbl[17] = '{1'b0, 4'b1011, 4'b1000, 4'b0000, 4'b1000, 4'b1000};
    tbl[18] = '{1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 4'b1000};

    repeat (2) @(posedge clk_i);
    #1;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 19; i++) begin
      rst_i = tbl[i].rst; req_i = tbl[i].req; lock_i = tbl[i].lock; wen_i = tbl[i].wen;
      @(negedge clk_i);
      chk($sformatf("tbl%0d_gnt", i), gnt_o, tbl[i].gnt);
      chk($sformatf("tbl%0d_rvalid", i), rvalid_o, tbl[i].rv);
      chk($sformatf("tbl%0d_en", i), sram_en_o, |tbl[i].gnt);
      next_cycle();
    end

    // ---------------- read of preloaded word ----------------
    do_reset();
    req_i = 4'b0001; set_req(0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
    @(negedge clk_i);
    chk("preload_wen", sram_wen_o, 1'b1);
    next_cycle();
    req_i = 4'b0100; set_req(2, 1'b0, 4'h0, 32'h40, 32'h0);
    @(negedge clk_i);
    chk("rd2_gnt", gnt_o, 4'b0100);
    chk("rd2_en", sram_en_o, 1'b1);
    chk("rd2_wen", sram_wen_o, 1'b0);
    chk("rd2_addr", sram_addr_o, 32'h40);
    chk("rv_after_write", rvalid_o, 4'b0000);
    next_cycle();
    req_i = 4'b0000;
    @(negedge clk_i);
    chk("rd2_rvalid", rvalid_o, 4'b0100);
    chk("rd2_rdata", rdata_o, 32'hDEADBEEF);
    chk("idle_en", sram_en_o, 1'b0);
    chk("idle_addr", sram_addr_o, 32'h0);
    next_cycle();

    // ---------------- masked write then read ----------------
    req_i = 4'b0001; set_req(0, 1'b1, 4'hF, 32'h10, 32'hAAAAAAAA);
    next_cycle();
    set_req(0, 1'b1, 4'b0011, 32'h10, 32'h12345678);
    @(negedge clk_i);
    chk("wr_gnt", gnt_o, 4'b0001);
    chk("wr_bm", sram_bm_o, 4'b0011);
    chk("wr_dat", sram_dat_o, 32'h12345678);
    next_cycle();
    req_i = 4'b0010; set_req(1, 1'b0, 4'h0, 32'h10, 32'h0);
    @(negedge clk_i);
    chk("rd1_gnt", gnt_o, 4'b0010);
    chk("rd1_rv_pre", rvalid_o, 4'b0000);
    next_cycle();
    // back-to-back reads from two requesters
    req_i = 4'b0101; set_req(0, 1'b0, 4'h0, 32'h40, 32'h0); set_req(2, 1'b0, 4'h0, 32'h10, 32'h0);
    @(negedge clk_i);
    chk("rd1_rvalid", rvalid_o, 4'b0010);
    chk("rd1_rdata", rdata_o, 32'hAAAA5678);
    chk("b2b_gnt_a", gnt_o, 4'b0100);
    next_cycle();
    @(negedge clk_i);
    chk("b2b_gnt_b", gnt_o, 4'b0001);
    chk("b2b_rv_a", rvalid_o, 4'b0100);
    chk("b2b_rd_a", rdata_o, 32'hAAAA5678);
    next_cycle();
    req_i = 4'b0000;
    @(negedge clk_i);
    chk("b2b_rv_b", rvalid_o, 4'b0001);
    chk("b2b_rd_b", rdata_o, 32'hDEADBEEF);
    next_cycle();

    // ---------------- reset right after a read grant ----------------
    req_i = 4'b1000; set_req(3, 1'b0, 4'h0, 32'h40, 32'h0);
    @(negedge clk_i);
    chk("rst_rd_gnt", gnt_o, 4'b1000);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    req_i = 4'b1001;
    @(negedge clk_i);
    chk("rst_rv_supp", rvalid_o, 4'b0000);
    chk("rst_first_gnt", gnt_o, 4'b0001);
    next_cycle();
    req_i = 4'b0000;
    @(negedge clk_i);
    chk("rst_after_rv", rvalid_o, 4'b0001);
    chk("rst_after_rd", rdata_o, 32'hDEADBEEF);
    next_cycle();

    // ---------------- randomized traffic vs model ----------------
    for (int a = 0; a < 16; a++) begin
      ea = $urandom;
      req_i = 4'b0001; set_req(0, 1'b1, 4'hF, 32'(a * 4), ea);
      ref_mem[a] = ea;
      next_cycle();
    end
    do_reset();
    m_ptr = 0; m_owner = -1; exp_rv = '0; exp_rdata = '0; last_g = -1;
    for (int k = 0; k < N; k++) begin pend[k] = 1'b0; waitc[k] = 0; end

    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (last_g == k) pend[k] = 1'b0;
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          set_req(k, 1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 15) * 4), $urandom);
        end
        req_i[k] = pend[k];
      end
      lock_i = N'($urandom & $urandom & $urandom);

      @(negedge clk_i);
      chk("rnd_rvalid", rvalid_o, exp_rv);
      if (exp_rv != '0) chk("rnd_rdata", rdata_o, exp_rdata);

      g  = model_pick();
      eg = (g >= 0) ? N'(1 << g) : '0;
      chk("rnd_gnt", gnt_o, eg);
      chk("rnd_onehot", $onehot0(gnt_o), 1'b1);
      chk("rnd_en", sram_en_o, g >= 0);
      if (g >= 0) begin
        chk("rnd_wen", sram_wen_o, wen_i[g]);
        chk("rnd_addr", sram_addr_o, addr_i[g*AW +: AW]);
        chk("rnd_bm", sram_bm_o, bm_i[g*BW +: BW]);
        chk("rnd_dat", sram_dat_o, dat_i[g*DW +: DW]);
      end

      gd = -1;
      for (int k = 0; k < N; k++) if (gnt_o[k]) gd = k;
      if (gd >= 0) begin
        if (m_owner >= 0 || lock_i[gd]) begin
          for (int k = 0; k < N; k++) waitc[k] = 0;
        end else begin
          chk("rnd_fair", waitc[gd] <= N - 1, 1'b1);
          waitc[gd] = 0;
          for (int k = 0; k < N; k++) if (k != gd && req_i[k]) waitc[k]++;
        end
      end

      exp_rv = '0;
      if (g >= 0) begin
        ea = addr_i[g*AW +: AW];
        if (wen_i[g]) ref_mem[ea[9:2]] = merge(ref_mem[ea[9:2]], dat_i[g*DW +: DW], bm_i[g*BW +: BW]);
        else begin
          exp_rv    = eg;
          exp_rdata = ref_mem[ea[9:2]];
        end
        m_ptr   = (g + 1) % N;
        m_owner = lock_i[g] ? g : -1;
      end else begin
        m_owner = -1;
      end
      last_g = g;
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
